// File: rtl/floo_vc_link_receiver.sv
`default_nettype none
// ============================================================================
// Module      : floo_vc_link_receiver
// Description : Receiving end of a virtual-channel link. Demultiplexes
//               NUM_VIRT_CHANNELS ready-first valid/ready channels (carried on
//               one shared lane or one lane per VC) into independent per-VC
//               FIFOs, so a stalled VC never blocks its neighbours. Flags
//               sticky protocol errors on the incoming link.
// Revision    : 1.0 - initial release
// ============================================================================
module floo_vc_link_receiver #(
    parameter int unsigned NUM_VIRT_CHANNELS = 2,
    parameter int unsigned NUM_PHYS_CHANNELS = 1,
    parameter type         FLIT_T            = logic,
    parameter int unsigned FIFO_DEPTH        = 2,
    parameter int unsigned CNT_WIDTH         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic  [NUM_VIRT_CHANNELS-1:0]                  valid_i,
    output logic  [NUM_VIRT_CHANNELS-1:0]                  ready_o,
    input  FLIT_T [NUM_PHYS_CHANNELS-1:0]                  data_i,
    output logic  [NUM_VIRT_CHANNELS-1:0]                  valid_o,
    input  logic  [NUM_VIRT_CHANNELS-1:0]                  ready_i,
    output FLIT_T [NUM_VIRT_CHANNELS-1:0]                  data_o,
    output logic  [NUM_VIRT_CHANNELS-1:0][CNT_WIDTH-1:0]   usage_o,
    output logic                                           err_o
);

    // A depth-1 FIFO still needs a 1-bit pointer to keep the vectors legal.
    localparam int unsigned c_ptr_width = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0]   c_depth_cnt = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [c_ptr_width-1:0] c_last_ptr  = c_ptr_width'(FIFO_DEPTH - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    if (NUM_VIRT_CHANNELS < 1) begin : g_bad_vc
        $fatal(1, "floo_vc_link_receiver: NUM_VIRT_CHANNELS must be >= 1");
    end
    if (!(NUM_PHYS_CHANNELS == 1 || NUM_PHYS_CHANNELS == NUM_VIRT_CHANNELS)) begin : g_bad_phys
        $fatal(1, "floo_vc_link_receiver: NUM_PHYS_CHANNELS must be 1 or NUM_VIRT_CHANNELS");
    end
    if (FIFO_DEPTH < 1) begin : g_bad_depth
        $fatal(1, "floo_vc_link_receiver: FIFO_DEPTH must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Protocol error detection
    // ------------------------------------------------------------------------
    logic [NUM_VIRT_CHANNELS-1:0] r_stall_prev;  // valid & !ready seen last cycle
    logic [NUM_VIRT_CHANNELS-1:0] w_drop;        // valid withdrawn while stalled
    logic                         w_multi;       // several VCs on one shared lane
    logic                         r_err;

    assign w_drop = r_stall_prev & ~valid_i;

    if (NUM_PHYS_CHANNELS == 1) begin : g_shared_lane
        // Clearing the lowest set bit leaves something only if two or more were set.
        assign w_multi = |(valid_i & (valid_i - NUM_VIRT_CHANNELS'(1)));
    end else begin : g_private_lanes
        assign w_multi = 1'b0;
    end

    // Remember stalled offers and latch any protocol violation until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_prev <= '0;
            r_err        <= 1'b0;
        end else begin
            r_stall_prev <= valid_i & ~ready_o;
            r_err        <= r_err | w_multi | (|w_drop);
        end
    end

    assign err_o = r_err;

    // ------------------------------------------------------------------------
    // Per-VC circular FIFOs
    // ------------------------------------------------------------------------
    for (genvar v = 0; v < NUM_VIRT_CHANNELS; v++) begin : g_vc
        FLIT_T                  r_mem [FIFO_DEPTH];
        logic [c_ptr_width-1:0] r_rd_ptr;
        logic [c_ptr_width-1:0] r_wr_ptr;
        logic [CNT_WIDTH-1:0]   r_count;
        logic                   w_push;
        logic                   w_pop;
        FLIT_T                  w_lane;

        if (NUM_PHYS_CHANNELS == 1) begin : g_lane_shared
            assign w_lane = data_i[0];
        end else begin : g_lane_own
            assign w_lane = data_i[v];
        end

        // Ready and valid come from registered occupancy only, so neither
        // valid_i nor ready_i reaches an output combinationally.
        assign ready_o[v] = (r_count < c_depth_cnt);
        assign valid_o[v] = (r_count != '0);
        assign data_o[v]  = r_mem[r_rd_ptr];
        assign usage_o[v] = r_count;

        assign w_push = valid_i[v] & ready_o[v];
        assign w_pop  = valid_o[v] & ready_i[v];

        // Flit storage; contents need no reset because count gates visibility.
        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_lane;
            end
        end

        // Pointer and occupancy bookkeeping with wrap at FIFO_DEPTH-1.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

`ifndef SYNTHESIS
        a_hold_stable: assert property (@(posedge clk_i)
            (valid_o[v] && !ready_i[v] && !rst_i) |=> ($stable(valid_o[v]) && $stable(data_o[v])))
            else $error("floo_vc_link_receiver: VC %0d output changed while stalled", v);

        a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
            r_count <= c_depth_cnt)
            else $error("floo_vc_link_receiver: VC %0d count overflow", v);
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_floo_vc_link_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_floo_vc_link_receiver
// Description : Scoreboard bench for floo_vc_link_receiver. DUT index 0 uses a
//               single shared lane, DUT index 1 uses one lane per VC. Accepted
//               flits are queued per VC; a negedge monitor pops and compares
//               every flit the DUT hands out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floo_vc_link_receiver;

    typedef logic [7:0] flit_t;

    logic clk;
    logic rst     [2];
    logic [1:0] valid_i [2];
    logic [1:0] ready_o [2];
    logic [1:0] valid_o [2];
    logic [1:0] ready_i [2];
    flit_t [1:0] data_o [2];
    logic [1:0][1:0] usage_o [2];
    logic err_o [2];
    flit_t [0:0] d1_data_i;
    flit_t [1:0] d2_data_i;

    int tests  = 0;
    int failed = 0;

    flit_t sb0[$], sb1[$], sb2[$], sb3[$];

    floo_vc_link_receiver #(
        .NUM_VIRT_CHANNELS(2), .NUM_PHYS_CHANNELS(1), .FLIT_T(flit_t), .FIFO_DEPTH(2)
    ) u_dut_shared (
        .clk_i(clk), .rst_i(rst[0]), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
        .data_i(d1_data_i), .valid_o(valid_o[0]), .ready_i(ready_i[0]),
        .data_o(data_o[0]), .usage_o(usage_o[0]), .err_o(err_o[0])
    );

    floo_vc_link_receiver #(
        .NUM_VIRT_CHANNELS(2), .NUM_PHYS_CHANNELS(2), .FLIT_T(flit_t), .FIFO_DEPTH(2)
    ) u_dut_lanes (
        .clk_i(clk), .rst_i(rst[1]), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
        .data_i(d2_data_i), .valid_o(valid_o[1]), .ready_i(ready_i[1]),
        .data_o(data_o[1]), .usage_o(usage_o[1]), .err_o(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sb_push(input int idx, input flit_t val);
        case (idx)
            0: sb0.push_back(val);
            1: sb1.push_back(val);
            2: sb2.push_back(val);
            default: sb3.push_back(val);
        endcase
    endtask

    task automatic sb_pop(input int idx, output flit_t val, output bit ok);
        ok  = 1'b0;
        val = '0;
        case (idx)
            0: if (sb0.size() > 0) begin val = sb0.pop_front(); ok = 1'b1; end
            1: if (sb1.size() > 0) begin val = sb1.pop_front(); ok = 1'b1; end
            2: if (sb2.size() > 0) begin val = sb2.pop_front(); ok = 1'b1; end
            default: if (sb3.size() > 0) begin val = sb3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic sb_clear(input int d);
        if (d == 0) begin sb0.delete(); sb1.delete(); end
        else        begin sb2.delete(); sb3.delete(); end
    endtask

    // Monitor: compare handed-out flits, then record flits the link accepts.
    always @(negedge clk) begin
        flit_t exp;
        bit    ok;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                sb_clear(d);
            end else begin
                for (int v = 0; v < 2; v++) begin
                    if (valid_o[d][v] && ready_i[d][v]) begin
                        sb_pop(d * 2 + v, exp, ok);
                        tests++;
                        if (!ok) begin
                            failed++;
                            $display("FAIL sb_dut%0d_vc%0d: got flit %h, expected no flit", d, v, data_o[d][v]);
                        end else if (data_o[d][v] !== exp) begin
                            failed++;
                            $display("FAIL sb_dut%0d_vc%0d: got flit %h, expected %h", d, v, data_o[d][v], exp);
                        end
                    end
                    if (valid_i[d][v] && ready_o[d][v]) begin
                        sb_push(d * 2 + v, (d == 0) ? d1_data_i[0] : d2_data_i[v]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = '{1'b1, 1'b1};
        valid_i = '{2'b00, 2'b00};
        ready_i = '{2'b00, 2'b00};
        d1_data_i = '0;
        d2_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = '{1'b0, 1'b0};

        // Reset and idle
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", ready_o[d], 2'b11);
            chk("rst_valid", valid_o[d], 2'b00);
            chk("rst_usage", usage_o[d], 4'h0);
            chk("rst_err",   err_o[d],   1'b0);
        end
        cyc();

        // Single-VC stream with ready held high
        ready_i[0] = 2'b01;
        valid_i[0] = 2'b01; d1_data_i[0] = 8'hA1;
        @(negedge clk); chk("lat_before", valid_o[0][0], 1'b0); cyc();
        d1_data_i[0] = 8'hA2;
        @(negedge clk); chk("lat_first", valid_o[0][0], 1'b1); cyc();
        d1_data_i[0] = 8'hA3; cyc();
        valid_i[0] = 2'b00; cyc();
        @(negedge clk); chk("stream_drained", usage_o[0][0], 2'd0); cyc();

        // Backpressure: third flit waits on the link
        ready_i[0] = 2'b00;
        valid_i[0] = 2'b01; d1_data_i[0] = 8'hB1; cyc();
        d1_data_i[0] = 8'hB2; cyc();
        d1_data_i[0] = 8'hB3;
        @(negedge clk);
        chk("bp_usage", usage_o[0][0], 2'd2);
        chk("bp_ready", ready_o[0][0], 1'b0);
        cyc();
        @(negedge clk); chk("bp_ready_hold", ready_o[0][0], 1'b0); cyc();

        // Full FIFO, single-cycle pop: ready rises only the next cycle
        ready_i[0] = 2'b01;
        @(negedge clk); chk("full_pop_ready_same", ready_o[0][0], 1'b0); cyc();
        ready_i[0] = 2'b00;
        @(negedge clk);
        chk("full_pop_ready_next", ready_o[0][0], 1'b1);
        chk("full_pop_usage", usage_o[0][0], 2'd1);
        cyc();
        valid_i[0] = 2'b00;
        @(negedge clk); chk("b3_accepted_usage", usage_o[0][0], 2'd2); cyc();
        ready_i[0] = 2'b01; repeat (3) cyc();
        ready_i[0] = 2'b00;

        // VC isolation: VC1 full and stalled, VC0 streams at full rate
        ready_i[0] = 2'b01;
        valid_i[0] = 2'b10; d1_data_i[0] = 8'hC1; cyc();
        d1_data_i[0] = 8'hC2; cyc();
        for (int i = 0; i < 10; i++) begin
            valid_i[0] = 2'b01; d1_data_i[0] = 8'hD0 + 8'(i);
            @(negedge clk);
            chk("iso_vc0_ready", ready_o[0][0], 1'b1);
            chk("iso_vc1_usage", usage_o[0][1], 2'd2);
            chk("iso_vc1_head",  data_o[0][1], 8'hC1);
            cyc();
        end
        valid_i[0] = 2'b00;
        @(negedge clk); chk("iso_vc1_ready", ready_o[0][1], 1'b0); cyc();
        cyc();
        ready_i[0] = 2'b11; repeat (3) cyc();
        ready_i[0] = 2'b00;
        @(negedge clk); chk("iso_err_clean", err_o[0], 1'b0); cyc();

        // Protocol error (a): two VCs valid on a shared lane
        valid_i[0] = 2'b11; d1_data_i[0] = 8'hE5; cyc();
        valid_i[0] = 2'b00;
        @(negedge clk); chk("err_multi", err_o[0], 1'b1); cyc();
        @(negedge clk); chk("err_multi_held", err_o[0], 1'b1); cyc();
        ready_i[0] = 2'b11; repeat (2) cyc();
        ready_i[0] = 2'b00;
        rst[0] = 1'b1; cyc();
        rst[0] = 1'b0;
        @(negedge clk);
        chk("err_cleared", err_o[0], 1'b0);
        chk("err_cleared_ready", ready_o[0], 2'b11);
        cyc();

        // Protocol error (b): valid withdrawn while stalled
        valid_i[0] = 2'b01; d1_data_i[0] = 8'hF1; cyc();
        d1_data_i[0] = 8'hF2; cyc();
        d1_data_i[0] = 8'hF3;
        @(negedge clk);
        chk("drop_ready", ready_o[0][0], 1'b0);
        chk("drop_err_before", err_o[0], 1'b0);
        cyc();
        valid_i[0] = 2'b00;
        @(negedge clk); chk("drop_err_pending", err_o[0], 1'b0); cyc();
        @(negedge clk); chk("drop_err", err_o[0], 1'b1); cyc();
        rst[0] = 1'b1; cyc();
        rst[0] = 1'b0;
        @(negedge clk);
        chk("drop_rst_err", err_o[0], 1'b0);
        chk("drop_rst_usage", usage_o[0], 4'h0);
        chk("drop_rst_valid", valid_o[0], 2'b00);
        cyc();

        // Multi-lane: distinct data per lane, then reset mid-operation
        valid_i[1] = 2'b11; d2_data_i = {8'h22, 8'h11}; cyc();
        valid_i[1] = 2'b00; rst[1] = 1'b1;
        @(negedge clk);
        chk("ml_usage0", usage_o[1][0], 2'd1);
        chk("ml_usage1", usage_o[1][1], 2'd1);
        chk("ml_valid", valid_o[1], 2'b11);
        chk("ml_data0", data_o[1][0], 8'h11);
        chk("ml_data1", data_o[1][1], 8'h22);
        cyc();
        rst[1] = 1'b0; ready_i[1] = 2'b11;
        @(negedge clk);
        chk("ml_rst_valid", valid_o[1], 2'b00);
        chk("ml_rst_usage", usage_o[1], 4'h0);
        cyc();
        repeat (3) cyc();
        valid_i[1] = 2'b11; d2_data_i = {8'h44, 8'h33}; cyc();
        valid_i[1] = 2'b00; repeat (3) cyc();
        @(negedge clk);
        chk("ml_err", err_o[1], 1'b0);

        // Every accepted flit must have been delivered
        chk("sb_drained", 32'(sb0.size() + sb1.size() + sb2.size() + sb3.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
